// File: rtl/rc5_pkg.sv
// Shared constants, FSM state encoding and rotate helpers for the RC5-32/12 block datapath.
package rc5_pkg;

    localparam int W         = 32;
    localparam int R         = 12;
    localparam int T         = 2 * R + 2;
    localparam int T_LENGTH  = $clog2(T);
    localparam int ROT_VALUE = $clog2(W);
    localparam int CNT_W     = $clog2(R + 1);

    typedef enum logic [2:0] {
        IDLE,
        RND_B,
        RND_A,
        FIN_B,
        FIN_A,
        DONE
    } state_e;

    typedef enum logic {
        ROT_RIGHT = 1'b0,
        ROT_LEFT  = 1'b1
    } rot_dir_e;

    // Doubling the word lets a plain shift act as a rotate, including amount 0.
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} >> n;
        return d[W-1:0];
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} << n;
        return d[2*W-1:W];
    endfunction

endpackage

// File: rtl/rc5_rotator.sv
// Combinational W-bit barrel rotator with selectable direction, shared by both half-round paths.
module rc5_rotator
    import rc5_pkg::*;
(
    input  logic [W-1:0]         value,
    input  logic [ROT_VALUE-1:0] amount,
    input  rot_dir_e             dir,
    output logic [W-1:0]         result
);

    always_comb begin
        result = (dir == ROT_LEFT) ? rotl(value, amount) : rotr(value, amount);
    end

endmodule

// File: rtl/rc5_decrypt.sv
// Iterative RC5-32/12 block decryptor, one half-round per clock, reading the shared S table.
// Optional encrypt path enabled by defining RC5_ENC_EN (adds the mode input).
module rc5_decrypt
    import rc5_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                key_ready,
    input  logic                start,
`ifdef RC5_ENC_EN
    input  logic                mode,
`endif
    input  logic [W-1:0]        A_in,
    input  logic [W-1:0]        B_in,
    output logic [T_LENGTH-1:0] S_address,
    input  logic [W-1:0]        S_sub_i,
    output logic                busy,
    output logic                out_valid,
    output logic [W-1:0]        A_out,
    output logic [W-1:0]        B_out
);

    state_e                state, state_nxt;
    logic [W-1:0]          a_q, b_q, a_nxt, b_nxt;
    logic [CNT_W-1:0]      i_q, i_nxt;
    logic [T_LENGTH-1:0]   addr_nxt;
    logic [W-1:0]          rot_value, rot_out;
    logic [ROT_VALUE-1:0]  rot_amount;
    logic                  odd_step;

`ifdef RC5_ENC_EN
    logic                  enc_q, enc_nxt;
    logic                  first_pair;
    rot_dir_e              rot_dir;
`endif

    assign busy     = (state != IDLE);
    assign odd_step = (state == RND_A) || (state == FIN_A);

    rc5_rotator u_rotator (
        .value  (rot_value),
        .amount (rot_amount),
`ifdef RC5_ENC_EN
        .dir    (rot_dir),
`else
        .dir    (ROT_RIGHT),
`endif
        .result (rot_out)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        i_nxt     = i_q;

        if (odd_step) begin
            rot_value  = a_q - S_sub_i;
            rot_amount = b_q[ROT_VALUE-1:0];
        end else begin
            rot_value  = b_q - S_sub_i;
            rot_amount = a_q[ROT_VALUE-1:0];
        end

`ifdef RC5_ENC_EN
        enc_nxt    = enc_q;
        rot_dir    = ROT_RIGHT;
        first_pair = (i_q == CNT_W'(R)) && ((state == RND_B) || (state == RND_A));
        if (enc_q) begin
            rot_dir    = ROT_LEFT;
            rot_value  = a_q ^ b_q;
            rot_amount = odd_step ? a_q[ROT_VALUE-1:0] : b_q[ROT_VALUE-1:0];
        end
`endif

        case (state)
            IDLE: begin
                if (start && key_ready) begin
                    a_nxt     = A_in;
                    b_nxt     = B_in;
                    i_nxt     = CNT_W'(R);
                    state_nxt = RND_B;
`ifdef RC5_ENC_EN
                    enc_nxt   = mode;
`endif
                end
            end
            RND_B: begin
                b_nxt     = rot_out ^ a_q;
                state_nxt = RND_A;
            end
            RND_A: begin
                a_nxt = rot_out ^ b_q;
                if (i_q == CNT_W'(1)) begin
                    state_nxt = FIN_B;
                end else begin
                    i_nxt     = i_q - 1'b1;
                    state_nxt = RND_B;
                end
            end
            FIN_B: begin
                b_nxt     = b_q - S_sub_i;
                state_nxt = FIN_A;
            end
            FIN_A: begin
                a_nxt     = a_q - S_sub_i;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef RC5_ENC_EN
        // Encrypt runs the same state walk: even steps update A, odd steps update B.
        if (enc_q) begin
            case (state)
                RND_B, FIN_B: begin
                    b_nxt = b_q;
                    a_nxt = first_pair ? a_q + S_sub_i : rot_out + S_sub_i;
                end
                RND_A, FIN_A: begin
                    a_nxt = a_q;
                    b_nxt = first_pair ? b_q + S_sub_i : rot_out + S_sub_i;
                end
                default: ;
            endcase
        end
`endif
    end

    // Address for the step about to be entered, so S_sub_i is ready in that cycle.
    always_comb begin
        addr_nxt = '0;
`ifdef RC5_ENC_EN
        if (enc_nxt) begin
            case (state_nxt)
                RND_B:   addr_nxt = T_LENGTH'(2 * (R - int'(i_nxt)));
                RND_A:   addr_nxt = T_LENGTH'(2 * (R - int'(i_nxt)) + 1);
                FIN_B:   addr_nxt = T_LENGTH'(2 * R);
                FIN_A:   addr_nxt = T_LENGTH'(2 * R + 1);
                default: addr_nxt = '0;
            endcase
        end else
`endif
        begin
            case (state_nxt)
                RND_B:   addr_nxt = T_LENGTH'({i_nxt, 1'b1});
                RND_A:   addr_nxt = T_LENGTH'({i_nxt, 1'b0});
                FIN_B:   addr_nxt = T_LENGTH'(1);
                default: addr_nxt = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            S_address <= '0;
            out_valid <= 1'b0;
            A_out     <= '0;
            B_out     <= '0;
`ifdef RC5_ENC_EN
            enc_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            i_q       <= i_nxt;
            S_address <= addr_nxt;
            out_valid <= (state == DONE);
`ifdef RC5_ENC_EN
            enc_q     <= enc_nxt;
`endif
            if (state == DONE) begin
                A_out <= a_q;
                B_out <= b_q;
            end
        end
    end

endmodule

// File: tb/tb_rc5_decrypt.sv
// Directed and randomized checks of rc5_decrypt against a reference RC5 model and key schedule.
module tb_rc5_decrypt;
    import rc5_pkg::*;

    localparam logic [W-1:0] P32  = 32'hB7E15163;
    localparam logic [W-1:0] Q32  = 32'h9E3779B9;
    localparam logic [W-1:0] CT_A = 32'hEEDBA521;
    localparam logic [W-1:0] CT_B = 32'h6D8F4B15;
    localparam int           LAT  = 2 * R + 3;

    logic                clk = 1'b0;
    logic                rst, key_ready, start;
    logic [W-1:0]        A_in, B_in, S_sub_i, A_out, B_out;
    logic [T_LENGTH-1:0] S_address;
    logic                busy, out_valid;
`ifdef RC5_ENC_EN
    logic                mode;
`endif

    logic [W-1:0] s_mem [T];
    int n_vec = 0;
    int n_err = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    assign S_sub_i = s_mem[S_address];

    always @(negedge clk) if (out_valid) n_pulses++;

    rc5_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .start     (start),
`ifdef RC5_ENC_EN
        .mode      (mode),
`endif
        .A_in      (A_in),
        .B_in      (B_in),
        .S_address (S_address),
        .S_sub_i   (S_sub_i),
        .busy      (busy),
        .out_valid (out_valid),
        .A_out     (A_out),
        .B_out     (B_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_rotl(input logic [W-1:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x << n) | (x >> (W - int'(n)));
    endfunction

    function automatic logic [W-1:0] m_rotr(input logic [W-1:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x >> n) | (x << (W - int'(n)));
    endfunction

    // Standard RC5 key expansion for a 16-byte all-zero key.
    task automatic zero_key_schedule();
        logic [W-1:0] l [4];
        logic [W-1:0] x, y, sum;
        int ii, jj;
        s_mem[0] = P32;
        for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + Q32;
        for (int k = 0; k < 4; k++) l[k] = '0;
        x = '0; y = '0; ii = 0; jj = 0;
        for (int k = 0; k < 3 * T; k++) begin
            x = m_rotl(s_mem[ii] + x + y, 5'd3);
            s_mem[ii] = x;
            sum = x + y;
            y = m_rotl(l[jj] + sum, sum[4:0]);
            l[jj] = y;
            ii = (ii + 1) % T;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic m_decrypt(input logic [W-1:0] ci_a, ci_b, output logic [W-1:0] pa, pb);
        logic [W-1:0] a, b;
        a = ci_a; b = ci_b;
        for (int i = R; i >= 1; i--) begin
            b = m_rotr(b - s_mem[2*i+1], a[4:0]) ^ a;
            a = m_rotr(a - s_mem[2*i], b[4:0]) ^ b;
        end
        pb = b - s_mem[1];
        pa = a - s_mem[0];
    endtask

    // Pulses start with (a,b); optionally re-pulses start 'repulse_at' cycles later.
    task automatic run_block(input logic [W-1:0] a, b, input int repulse_at,
                             output logic [W-1:0] ra, rb, output int lat,
                             output logic [T_LENGTH-1:0] first_addr, output logic first_busy);
        @(negedge clk);
        A_in = a; B_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_addr = S_address;
        first_busy = busy;
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (lat == repulse_at) begin
                A_in = ~a; B_in = b ^ 32'h5A5A_5A5A; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        ra = A_out;
        rb = B_out;
    endtask

    initial begin
        logic [W-1:0]        ra, rb, ea, eb, va, vb;
        logic [T_LENGTH-1:0] fa;
        logic                fb, busy_seen;
        int                  lat, p0;

        rst = 1'b1; key_ready = 1'b0; start = 1'b0; A_in = '0; B_in = '0;
`ifdef RC5_ENC_EN
        mode = 1'b0;
`endif
        zero_key_schedule();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_a_out", 64'(A_out), 64'(0));
        check("rst_b_out", 64'(B_out), 64'(0));
        check("rst_addr", 64'(S_address), 64'(0));
        rst = 1'b0;

        // start without key_ready must be ignored
        p0 = n_pulses;
        @(negedge clk);
        A_in = CT_A; B_in = CT_B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = 1'b0;
        repeat (LAT + 5) begin
            if (busy) busy_seen = 1'b1;
            @(negedge clk);
        end
        check("nokey_busy", 64'(busy_seen), 64'(0));
        check("nokey_valid", 64'(n_pulses - p0), 64'(0));

        // known vector
        key_ready = 1'b1;
        run_block(CT_A, CT_B, -1, ra, rb, lat, fa, fb);
        check("kv_first_addr", 64'(fa), 64'(2 * R + 1));
        check("kv_first_busy", 64'(fb), 64'(1));
        check("kv_latency", 64'(lat), 64'(LAT));
        check("kv_a_out", 64'(ra), 64'(32'h0000_0000));
        check("kv_b_out", 64'(rb), 64'(32'h0000_0000));
        check("kv_busy_at_valid", 64'(busy), 64'(0));
        @(negedge clk);
        check("kv_pulse_width", 64'(out_valid), 64'(0));

        // start re-pulsed mid-block is ignored
        p0 = n_pulses;
        run_block(CT_A, CT_B, 5, ra, rb, lat, fa, fb);
        check("rep_latency", 64'(lat), 64'(LAT));
        check("rep_a_out", 64'(ra), 64'(32'h0000_0000));
        check("rep_b_out", 64'(rb), 64'(32'h0000_0000));
        repeat (LAT + 5) @(negedge clk);
        check("rep_pulses", 64'(n_pulses - p0), 64'(1));

        // nonzero plaintext so the reset check below is meaningful
        m_decrypt(32'h1111_1111, 32'h2222_2222, ea, eb);
        run_block(32'h1111_1111, 32'h2222_2222, -1, ra, rb, lat, fa, fb);
        check("vec2_latency", 64'(lat), 64'(LAT));
        check("vec2_out", {ra, rb}, {ea, eb});

        // reset in the middle of a block
        @(negedge clk);
        A_in = CT_A; B_in = CT_B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_a_out", 64'(A_out), 64'(0));
        check("abort_b_out", 64'(B_out), 64'(0));
        check("abort_addr", 64'(S_address), 64'(0));
        rst = 1'b0;
        p0 = n_pulses;
        repeat (LAT + 5) @(negedge clk);
        check("abort_no_pulse", 64'(n_pulses - p0), 64'(0));
        run_block(CT_A, CT_B, -1, ra, rb, lat, fa, fb);
        check("post_abort_latency", 64'(lat), 64'(LAT));
        check("post_abort_out", {ra, rb}, 64'(0));

        // random S tables and ciphertexts, with forced edge rotation amounts
        for (int k = 0; k < 1000; k++) begin
            for (int j = 0; j < T; j++) s_mem[j] = $urandom;
            va = $urandom;
            vb = $urandom;
            case (k % 4)
                1: va[4:0] = 5'd0;
                2: va[4:0] = 5'd31;
                3: vb[4:0] = 5'd0;
                default: vb[4:0] = 5'd31;
            endcase
            m_decrypt(va, vb, ea, eb);
            run_block(va, vb, -1, ra, rb, lat, fa, fb);
            check("stress_out", {ra, rb}, {ea, eb});
            if (lat >= 60) check("stress_timeout", 64'(lat), 64'(LAT));
        end

`ifdef RC5_ENC_EN
        zero_key_schedule();
        mode = 1'b1;
        run_block('0, '0, -1, ra, rb, lat, fa, fb);
        check("enc_latency", 64'(lat), 64'(LAT));
        check("enc_out", {ra, rb}, {CT_A, CT_B});
        mode = 1'b0;
        run_block(ra, rb, -1, va, vb, lat, fa, fb);
        check("enc_roundtrip", {va, vb}, 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
